// File: rtl/uart_rx.sv
// Multi-byte 8N1 UART receiver, first byte lands in the MSB byte of dat.
// Optional inter-byte timeout: define UART_RX_TIMEOUT_EN.
module uart_rx #(
  parameter int N_BYT = 4,
  parameter int W_BAU = 10,
  parameter int N_STB = 1,
  parameter int N_TMO = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_BAU-1:0]   baud,
  input  logic               uart_rxd,
  output logic [8*N_BYT-1:0] dat,
  output logic               f_rcv,
  output logic               f_err
);

  localparam int W_PK = 8 * N_BYT;
  localparam int W_BC = $clog2(N_BYT + 1);
  localparam int W_SC = $clog2(N_STB + 1);

  localparam logic [2:0] S_BRK   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic             meta_q, rxs_q;
  logic [2:0]       st_q, st_d;
  logic [W_BAU-1:0] b_q, b_d;
  logic [W_BAU-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [W_SC-1:0]  stb_q, stb_d;
  logic [7:0]       byt_q, byt_d;
  logic [W_PK-1:0]  pkt_q, pkt_d, pkt_n;
  logic [W_BC-1:0]  nb_q, nb_d;
  logic [W_PK-1:0]  dat_q, dat_d;
  logic             rcv_q, rcv_d;
  logic             err_q, err_d;
  logic             tick;

`ifdef UART_RX_TIMEOUT_EN
  localparam int W_TM = W_BAU + $clog2(N_TMO + 1);
  logic [W_TM-1:0] tmo_q, tmo_d;
  logic [W_TM-1:0] tlim;
  assign tlim = W_TM'(N_TMO) * W_TM'(b_q);
`endif

  assign tick  = (cnt_q == W_BAU'(1));
  assign pkt_n = (pkt_q << 8) | W_PK'(byt_q);

  always_comb begin
    st_d  = st_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    stb_d = stb_q;
    byt_d = byt_q;
    pkt_d = pkt_q;
    nb_d  = nb_q;
    dat_d = dat_q;
    rcv_d = 1'b0;
    err_d = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    tmo_d = tmo_q;
`endif
    case (st_q)
      S_BRK: begin
        if (rxs_q) st_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rxs_q) begin
          b_d   = baud;
          cnt_d = baud >> 1;
          st_d  = S_START;
`ifdef UART_RX_TIMEOUT_EN
          tmo_d = '0;
        end else if (nb_q != '0) begin
          if (tmo_q + W_TM'(1) >= tlim) begin
            err_d = 1'b1;
            nb_d  = '0;
            pkt_d = '0;
            tmo_d = '0;
          end else begin
            tmo_d = tmo_q + W_TM'(1);
          end
`endif
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - W_BAU'(1);
        end else if (!rxs_q) begin
          cnt_d = b_q;
          bit_d = '0;
          st_d  = S_DATA;
        end else begin
          st_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - W_BAU'(1);
        end else begin
          byt_d = {rxs_q, byt_q[7:1]};
          cnt_d = b_q;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            stb_d = '0;
            st_d  = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - W_BAU'(1);
        end else if (!rxs_q) begin
          err_d = 1'b1;
          nb_d  = '0;
          pkt_d = '0;
          st_d  = S_BRK;
        end else if (stb_q == W_SC'(N_STB - 1)) begin
          // Go IDLE mid stop bit so a back-to-back start edge is caught
          pkt_d = pkt_n;
          st_d  = S_IDLE;
          if (nb_q == W_BC'(N_BYT - 1)) begin
            dat_d = pkt_n;
            rcv_d = 1'b1;
            nb_d  = '0;
          end else begin
            nb_d = nb_q + W_BC'(1);
          end
        end else begin
          stb_d = stb_q + W_SC'(1);
          cnt_d = b_q;
        end
      end
      default: st_d = S_BRK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
      st_q   <= S_BRK;
      b_q    <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      stb_q  <= '0;
      byt_q  <= '0;
      pkt_q  <= '0;
      nb_q   <= '0;
      dat_q  <= '0;
      rcv_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tmo_q  <= '0;
`endif
    end else begin
      meta_q <= uart_rxd;
      rxs_q  <= meta_q;
      st_q   <= st_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      stb_q  <= stb_d;
      byt_q  <= byt_d;
      pkt_q  <= pkt_d;
      nb_q   <= nb_d;
      dat_q  <= dat_d;
      rcv_q  <= rcv_d;
      err_q  <= err_d;
`ifdef UART_RX_TIMEOUT_EN
      tmo_q  <= tmo_d;
`endif
    end
  end

  assign dat   = dat_q;
  assign f_rcv = rcv_q;
  assign f_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: two instances (1 and 2 stop bits),
// directed link scenarios plus randomized packets against a byte-queue model.
module tb_uart_rx;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  baud, baud2;
  logic        rxd, rxd2;
  logic [31:0] dat, dat2;
  logic        f_rcv, f_err, f_rcv2, f_err2;

  int nchk = 0;
  int nfail = 0;

  ev_t        exq[2][$];
  logic [7:0] byq[2][$];
  logic [31:0] mdat[2];

  always #5 clk = ~clk;

  uart_rx #(.N_BYT(4), .W_BAU(10), .N_STB(1), .N_TMO(20)) dut (
    .clk(clk), .rst(rst), .baud(baud), .uart_rxd(rxd),
    .dat(dat), .f_rcv(f_rcv), .f_err(f_err)
  );

  uart_rx #(.N_BYT(4), .W_BAU(10), .N_STB(2), .N_TMO(20)) dut2 (
    .clk(clk), .rst(rst), .baud(baud2), .uart_rxd(rxd2),
    .dat(dat2), .f_rcv(f_rcv2), .f_err(f_err2)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  // Reference model: a received byte either completes a packet or errors
  task automatic mdl_byte(input int i, input logic [7:0] b, input bit good);
    if (!good) begin
      byq[i].delete();
      exq[i].push_back('{1'b1, mdat[i]});
    end else begin
      byq[i].push_back(b);
      if (byq[i].size() == 4) begin
        mdat[i] = {byq[i][0], byq[i][1], byq[i][2], byq[i][3]};
        exq[i].push_back('{1'b0, mdat[i]});
        byq[i].delete();
      end
    end
  endtask

  task automatic line(input int i, input logic v);
    if (i == 0) rxd = v;
    else rxd2 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input int bb,
                           input int nstop, input bit bad, input bit mdl);
    if (i == 0) baud = 10'(bb);
    else baud2 = 10'(bb);
    line(i, 1'b0);
    idle(bb);
    for (int k = 0; k < 8; k++) begin
      line(i, b[k]);
      idle(bb);
    end
    if (mdl) mdl_byte(i, b, !bad);
    for (int s = 0; s < nstop; s++) begin
      line(i, !(bad && s == 0));
      idle(bb);
    end
    line(i, 1'b1);
  endtask

  task automatic send_pkt(input int i, input logic [31:0] w, input int bb,
                          input int nstop);
    logic [31:0] t;
    t = w;
    for (int k = 3; k >= 0; k--) send_byte(i, t[8*k +: 8], bb, nstop, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (f_rcv && f_err) chk("both_flags0", 32'd1, 32'd0);
    if (f_rcv || f_err) begin
      if (exq[0].size() == 0) begin
        chk("unexpected_evt0", {f_rcv, f_err}, 32'd0);
      end else begin
        e = exq[0].pop_front();
        chk("evt_err0", 32'(f_err), 32'(e.err));
        chk("evt_dat0", dat, e.dat);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (f_rcv2 && f_err2) chk("both_flags1", 32'd1, 32'd0);
    if (f_rcv2 || f_err2) begin
      if (exq[1].size() == 0) begin
        chk("unexpected_evt1", {f_rcv2, f_err2}, 32'd0);
      end else begin
        e = exq[1].pop_front();
        chk("evt_err1", 32'(f_err2), 32'(e.err));
        chk("evt_dat1", dat2, e.dat);
      end
    end
  end

  initial begin
    mdat[0] = '0;
    mdat[1] = '0;
    rst   = 1'b1;
    rxd   = 1'b1;
    rxd2  = 1'b1;
    baud  = 10'd10;
    baud2 = 10'd4;
    idle(4);
    chk("rst_dat0", dat, 32'd0);
    chk("rst_flags0", {f_rcv, f_err}, 32'd0);
    chk("rst_dat1", dat2, 32'd0);
    chk("rst_flags1", {f_rcv2, f_err2}, 32'd0);
    rst = 1'b0;
    idle(10);

    send_pkt(0, 32'h12345678, 10, 1);
    idle(30);

    // Short low glitch must read as a false start
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(40);
    send_pkt(0, 32'h0BADF00D, 10, 1);
    idle(30);

    send_byte(0, 8'h11, 10, 1, 1'b0, 1'b1);
    send_byte(0, 8'h22, 10, 1, 1'b0, 1'b1);
`ifdef UART_RX_TIMEOUT_EN
    byq[0].delete();
    exq[0].push_back('{1'b1, mdat[0]});
`endif
    idle(25 * 10);
    send_pkt(0, 32'hDEADBEEF, 10, 1);
    idle(30);

    send_byte(0, 8'h5A, 10, 1, 1'b0, 1'b1);
    send_byte(0, 8'h3C, 10, 1, 1'b1, 1'b1);
    idle(30);
    send_pkt(0, 32'hA5A5A5A5, 10, 1);
    idle(30);

    send_byte(0, 8'h77, 10, 1, 1'b0, 1'b1);
    send_byte(0, 8'h66, 10, 1, 1'b0, 1'b1);
    fork
      send_byte(0, 8'hFF, 10, 1, 1'b0, 1'b0);
      begin
        idle(45);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        byq[0].delete();
        byq[1].delete();
        mdat[0] = '0;
        mdat[1] = '0;
        chk("midrst_dat", dat, 32'd0);
        chk("midrst_flags", {f_rcv, f_err}, 32'd0);
      end
    join
    idle(40);
    send_pkt(0, 32'hC0FFEE42, 10, 1);
    idle(30);

    send_pkt(1, 32'h00FF0180, 4, 2);
    idle(30);

    for (int p = 0; p < 25; p++) begin
      int bb;
      bb = $urandom_range(16, 4);
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        bit bad;
        int ns;
        b   = 8'($urandom);
        ns  = $urandom_range(2, 1);
        bad = ($urandom_range(15, 0) == 0);
        send_byte(0, b, bb, ns, bad, 1'b1);
        if (bad) idle(2 * bb);
        else idle($urandom_range(2 * bb, 0));
      end
    end

    for (int p = 0; p < 6; p++) begin
      send_pkt(1, $urandom, $urandom_range(12, 4), 2);
      idle($urandom_range(20, 0));
    end

    idle(200);
    chk("drain0", 32'(exq[0].size()), 32'd0);
    chk("drain1", 32'(exq[1].size()), 32'd0);
    chk("final_dat0", dat, mdat[0]);
    chk("final_dat1", dat2, mdat[1]);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Multi-byte UART receiver; the receive end of the team's fixed-length UART link. Samples the RxD line, deserialises N_BYT consecutive 8N1-style frames (N_STB stop bits, no parity) and presents them as one word with a one-cycle strobe. Used on board-test and control paths opposite the multi-byte transmitter. Byte order matches it: the first byte on the wire lands in the MSB byte of `dat`.

## Interface
- `N_BYT`, 4: bytes per packet.
- `W_BAU`, 10: width of baud counter and `baud` port.
- `N_STB`, 1: stop bits checked per byte (min 1).
- `N_TMO`, 20: inter-byte timeout in bit periods (used only with `UART_RX_TIMEOUT_EN`).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `baud`  in  W_BAU  clocks per bit (min 4); sampled at each start-bit detect.
- `uart_rxd`  in  1  RxD line, asynchronous, idle high.
- `dat`  out  8*N_BYT  last complete packet; first received byte in `dat[8*N_BYT-1 -: 8]`.
- `f_rcv`  out  1  one-cycle pulse: `dat` updated with a new packet.
- `f_err`  out  1  one-cycle pulse: framing error or timeout; partial packet discarded.

## Operation
- RxD passes a 2-flop synchroniser (reset value 1); all logic uses synchronised `rxs`.
- States: BRK, IDLE, START, DATA, STOP.
- BRK: wait for `rxs`==1, then IDLE. Entered after reset and after a framing error.
- IDLE: `rxs`==0 → latch `baud` as B, load baud counter with floor(B/2), go START.
- START: at counter expiry sample `rxs`.
  - 0 → reload B, go DATA.
  - 1 → false start, go IDLE silently (no `f_err`).
- DATA: sample every B clocks; 8 bits, LSB first, shifted into byte register; then STOP.
- STOP: N_STB samples, B apart.
  - Any sample 0 → `f_err` pulse, clear byte count and packet buffer, go BRK.
  - All 1 → byte appended to packet shift buffer, byte count +1.
    - If count == N_BYT: copy buffer to `dat`, pulse `f_rcv`, count = 0.
    - Go IDLE either way. No wait for full stop-bit end; next start edge is accepted immediately.
- Byte count width `$clog2(N_BYT+1)`. Bit counter counts to 8 and to N_STB independently; no wrap beyond.
- `dat` holds its value until the next complete packet; it is never cleared by errors.
- Reset: `dat`=0, `f_rcv`=0, `f_err`=0, counts 0, state BRK, synchroniser 1. Any frame in progress is lost. A line held low at reset release is not taken as a start bit.

## Timing
- Start detect: the IDLE→START transition happens in the cycle `rxs` is first seen low, which is 2 clocks after the pin edge.
- Sample points: floor(B/2) clocks after detect for start; each further bit B clocks later.
- `f_rcv` and new `dat` are asserted in the cycle after the last stop-bit sample; `f_rcv` lasts 1 cycle.
- `f_err` is asserted in the cycle after the failing stop sample, or after timeout expiry; it lasts 1 cycle.
- `f_rcv` and `f_err` are never high in the same cycle.
- A packet from a transmitter at the same `baud` with back-to-back frames is received without loss at any baud ≥ 4.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - In IDLE with byte count > 0, count idle clocks.
  - When the count reaches N_TMO*B: pulse `f_err`, clear byte count and buffer, stay IDLE.
  - The idle count is cleared on every start detect.
- Not defined: no timeout logic. A partial packet is held indefinitely, and the next bytes complete it.

## Test plan
- N_BYT=4, baud=10, N_STB=1: transmit 0x12,0x34,0x56,0x78 back-to-back → exactly one `f_rcv`, `dat`=0x12345678, `f_err` never high.
- Low glitch of 3 clocks on RxD at baud=10 → no `f_rcv`, no `f_err`. A following valid packet is received correctly.
- Stop bit forced 0 on byte 2 → one `f_err`, no `f_rcv`, `dat` unchanged. After the line returns high, packet 0xA5A5A5A5 → `dat`=0xA5A5A5A5.
- With `UART_RX_TIMEOUT_EN`, N_TMO=20:
  - Send 2 bytes, then idle 25 bit periods → one `f_err`.
  - Then 0xDEADBEEF → `dat`=0xDEADBEEF.
  - Without the macro, the same sequence yields `f_rcv` with the first 2 bytes followed by 0xDEAD.
- `rst` pulsed mid byte 3 → `dat`=0, flags 0. The remainder of that packet produces no `f_rcv`; the next full packet is received correctly.
- baud=4, N_STB=2, 4-byte packet 0x00FF0180 → `dat`=0x00FF0180, one `f_rcv`.
